maxmin_reduce: RTL and testbench
================================

Name: maxmin_reduce

Overview:
- Start/done sequential reduction unit. It is the parametrised successor of the team's two-operand max block.
- Accepts a run of COUNT operands over a valid/ready stream and returns the maximum or minimum value plus the index of the winning element.
- Selectable signed or unsigned compare.
- Sits beside the other FSM-style compute blocks and is driven by a controller that pulses start and waits for done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- MAX_COUNT, 16, largest number of operands per run; must be >= 1.
- CNT_W, $clog2(MAX_COUNT+1), width of the count port.
- IDX_W, $clog2(MAX_COUNT) (minimum 1), width of the index output.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request a new run; sampled only in IDLE.
- count  in  CNT_W  number of operands in the run; sampled with start.
- mode  in  1  0 = maximum, 1 = minimum; sampled with start.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- in_valid  in  1  operand on in_data is valid.
- in_data  in  WIDTH  operand.
- in_ready  out  1  block accepts an operand this cycle.
- result  out  WIDTH  winning value; held until overwritten.
- index  out  IDX_W  0-based position of the winner within the run.
- done  out  1  level; high from run completion until the next accepted start.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; result = 0; index = 0; done = 0; internal best, best_idx and element counter = 0.
  - in_ready and busy drop in the same cycle reset asserts. A run in flight is abandoned with no partial result.
- States: IDLE, RUN, FINISH.
- IDLE:
  - in_ready = 0.
  - On start = 1: latch count, mode and is_signed; clear done; clear the element counter.
  - If count == 0, go to FINISH with best = 0 and best_idx = 0 (empty run). Otherwise go to RUN.
  - A count greater than MAX_COUNT is clamped to MAX_COUNT.
- RUN:
  - in_ready = 1 combinationally from state.
  - Handshake occurs when in_valid && in_ready.
  - First handshake (counter == 0): best <= in_data; best_idx <= 0.
  - Later handshakes: replace best/best_idx only when in_data is strictly greater (mode 0) or strictly less (mode 1) than best, under the latched signedness. Ties keep the earliest index.
  - The counter increments on each handshake. The handshake that brings the counter to the latched count moves the FSM to FINISH.
  - Cycles with in_valid low are stalls: no state change, no limit on stall length.
- FINISH:
  - in_ready = 0. On the next edge: result <= best; index <= best_idx; done <= 1; state <= IDLE.
- Latency:
  - The last handshake edge loads best. The FINISH edge follows it, so result and done are visible 2 edges after the last handshake.
  - For count == 0, result and done are visible 2 edges after the start edge.
- start while busy is ignored, with no effect on the run in progress.
- start in the same cycle done is high (IDLE) is accepted, and done clears on that edge.
- The compare is WIDTH bits wide with no extension beyond WIDTH. Signed mode interprets the MSB as sign.

Decomposition:
- Shared package maxmin_pkg contains:
  - state enum (IDLE, RUN, FINISH);
  - mode constants MODE_MAX = 0 and MODE_MIN = 1.
- One natural combinational sub-module, maxmin_cmp. It takes a, b, mode and is_signed and outputs better (strict, per the rules above). It is instantiated once on in_data vs best.

Test Plan:
- Unsigned max, count=4, data 5, 9, 3, 9 -> result=9, index=1 (tie keeps the first), done high 2 edges after the 4th handshake.
- Signed min, count=3, data 0x00000002, 0xFFFFFFF0, 0x7FFFFFFF -> result=0xFFFFFFF0, index=1. The same data with is_signed=0 and mode=min -> result=2, index=0.
- count=1, data 0xDEADBEEF, mode=max -> result=0xDEADBEEF, index=0. count=0 -> result=0, index=0, done high 2 edges after start, in_ready never high.
- Backpressure: count=3, in_valid toggles with 2-cycle gaps, data 1, 7, 4 -> result=7, index=1. A start pulse mid-run is ignored, and the run completes normally.
- Reset asserted asynchronously mid-RUN after 2 of 4 handshakes -> in_ready, busy, done, result and index all 0 immediately. A following clean run (max of 10, 20) -> result=20, index=1.
- Back-to-back runs: start held high in the cycle done rises -> done clears on the next edge, and the second run (min of 8, 6, 6) ends with result=6, index=1.

Source files
------------

// File: rtl/maxmin_pkg.sv
// Shared definitions for the max/min reduction unit: FSM state encoding and
// compare-mode constants used by the top level and the comparator.
package maxmin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/maxmin_cmp.sv
// Strict "a beats b" comparator: a > b for maximum, a < b for minimum, under
// either two's-complement or unsigned interpretation of the full WIDTH bits.
module maxmin_cmp
  import maxmin_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             is_signed,
  output logic             better
);

  logic gt;
  logic lt;

  // NOTE: every variable is assigned on every path through this block, so no
  // latch can be inferred; add defaults first if this logic ever grows branches.
  always_comb begin
    if (is_signed) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    better = (mode == MODE_MIN) ? lt : gt;
  end

endmodule

// File: rtl/maxmin_reduce.sv
// Start/done reduction unit: streams up to MAX_COUNT operands over valid/ready
// and reports the maximum or minimum value together with its 0-based index.
module maxmin_reduce
  import maxmin_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_COUNT = 16,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1),
  parameter int IDX_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             mode,
  input  logic             is_signed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [IDX_W-1:0] index,
  output logic             done,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] elem_cnt;
  logic             mode_q;
  logic             signed_q;
  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] best_idx;

  logic [CNT_W-1:0] count_clamped;
  logic [CNT_W-1:0] cnt_next;
  logic             handshake;
  logic             better;

  // Derived purely from state so an asynchronous reset drops them at once.
  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);

  always_comb begin
    count_clamped = (count > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : count;
    cnt_next      = elem_cnt + CNT_W'(1);
    handshake     = in_valid && in_ready;
  end

  maxmin_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a        (in_data),
    .b        (best),
    .mode     (mode_q),
    .is_signed(signed_q),
    .better   (better)
  );

  // NOTE: all state here is registered with non-blocking assignments so every
  // right-hand side sees pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      limit    <= '0;
      elem_cnt <= '0;
      mode_q   <= MODE_MAX;
      signed_q <= 1'b0;
      best     <= '0;
      best_idx <= '0;
      result   <= '0;
      index    <= '0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            limit    <= count_clamped;
            mode_q   <= mode;
            signed_q <= is_signed;
            elem_cnt <= '0;
            done     <= 1'b0;
            if (count_clamped == '0) begin
              // Empty run reports zero at index zero.
              best     <= '0;
              best_idx <= '0;
              state    <= FINISH;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (handshake) begin
            if (elem_cnt == '0) begin
              best     <= in_data;
              best_idx <= '0;
            end else if (better) begin
              // Strict compare: ties keep the earliest index.
              best     <= in_data;
              best_idx <= elem_cnt[IDX_W-1:0];
            end
            elem_cnt <= cnt_next;
            if (cnt_next == limit) begin
              state <= FINISH;
            end
          end
        end

        FINISH: begin
          result <= best;
          index  <= best_idx;
          done   <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxmin_reduce.sv
// Self-checking bench for maxmin_reduce: table-driven runs plus hand-written
// corner sequences, with expected results queued at start and popped at done.
module tb_maxmin_reduce;
  import maxmin_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  count;
  logic        mode;
  logic        is_signed;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] result;
  logic [3:0]  index;
  logic        done;
  logic        busy;

  maxmin_reduce dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .count    (count),
    .mode     (mode),
    .is_signed(is_signed),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .result   (result),
    .index    (index),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  i;
  } exp_t;

  typedef struct {
    logic        mode;
    logic        sgn;
    int          cnt;
    logic [31:0] d [4];
    logic [31:0] er;
    logic [3:0]  ei;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void set_vec(input int k, input logic m, input logic s, input int c,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3,
                                  input logic [31:0] er, input logic [3:0] ei,
                                  input string name);
    vecs[k].mode = m;
    vecs[k].sgn  = s;
    vecs[k].cnt  = c;
    vecs[k].d[0] = d0;
    vecs[k].d[1] = d1;
    vecs[k].d[2] = d2;
    vecs[k].d[3] = d3;
    vecs[k].er   = er;
    vecs[k].ei   = ei;
    vecs[k].name = name;
  endfunction

  // Pulse start for one edge; returns #1 after the accepting edge.
  task automatic do_start(input logic m, input logic s, input logic [4:0] c);
    mode = m; is_signed = s; count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one operand and hold it until it is accepted (bounded wait).
  task automatic send(input logic [31:0] d);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the final handshake (or start) edge: done must rise on the next edge.
  task automatic finish_check(input string name);
    exp_t e;
    check({name, "_done_early"}, {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_result"}, result, e.r);
      check({name, "_index"}, {28'b0, index}, {28'b0, e.i});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; count = '0; mode = MODE_MAX; is_signed = 1'b0;
    in_valid = 1'b0; in_data = '0;

    set_vec(0, MODE_MAX, 1'b0, 4, 32'd5, 32'd9, 32'd3, 32'd9, 32'd9, 4'd1, "umax_tie");
    set_vec(1, MODE_MIN, 1'b1, 3, 32'h2, 32'hFFFFFFF0, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFF0, 4'd1, "smin");
    set_vec(2, MODE_MIN, 1'b0, 3, 32'h2, 32'hFFFFFFF0, 32'h7FFFFFFF, 32'h0, 32'h2, 4'd0, "umin");
    set_vec(3, MODE_MAX, 1'b0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 4'd0, "one");
    set_vec(4, MODE_MAX, 1'b1, 3, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h0, 4'd2, "smax");
    set_vec(5, MODE_MAX, 1'b0, 3, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF, 4'd0, "umax");
    set_vec(6, MODE_MIN, 1'b0, 4, 32'd7, 32'd4, 32'd4, 32'd4, 32'd4, 4'd1, "min_tie");
    set_vec(7, MODE_MIN, 1'b1, 4, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h1, 32'h80000000, 4'd1, "smin_edge");

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_index", {28'b0, index}, 32'd0);

    // Table-driven runs.
    for (int k = 0; k < 8; k++) begin
      do_start(vecs[k].mode, vecs[k].sgn, 5'(vecs[k].cnt));
      sb.push_back('{r: vecs[k].er, i: vecs[k].ei});
      for (int j = 0; j < vecs[k].cnt; j++) send(vecs[k].d[j]);
      finish_check(vecs[k].name);
    end

    // Empty run: in_ready never rises, result and index read zero.
    do_start(MODE_MAX, 1'b0, 5'd0);
    sb.push_back('{r: 32'd0, i: 4'd0});
    check("empty_in_ready0", {31'b0, in_ready}, 32'd0);
    check("empty_busy", {31'b0, busy}, 32'd1);
    finish_check("empty");
    check("empty_in_ready1", {31'b0, in_ready}, 32'd0);

    // Count above MAX_COUNT is clamped to 16 operands.
    do_start(MODE_MAX, 1'b0, 5'd20);
    sb.push_back('{r: 32'd100, i: 4'd10});
    for (int j = 0; j < 16; j++) send((j == 10) ? 32'd100 : 32'(j * 3));
    finish_check("clamp");

    // Backpressure with 2-cycle gaps and an ignored mid-run start.
    do_start(MODE_MAX, 1'b0, 5'd3);
    sb.push_back('{r: 32'd7, i: 4'd1});
    send(32'd1);
    mode = MODE_MIN; count = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = MODE_MAX;
    check("bp_busy", {31'b0, busy}, 32'd1);
    check("bp_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(32'd7);
    repeat (2) @(posedge clk);
    #1;
    send(32'd4);
    finish_check("backpressure");

    // Asynchronous reset mid-run after 2 of 4 handshakes.
    do_start(MODE_MAX, 1'b0, 5'd4);
    send(32'd11);
    send(32'd22);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_index", {28'b0, index}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("arst_done_after", {31'b0, done}, 32'd0);
    do_start(MODE_MAX, 1'b0, 5'd2);
    sb.push_back('{r: 32'd20, i: 4'd1});
    send(32'd10);
    send(32'd20);
    finish_check("post_reset");

    // Back-to-back: start accepted in the cycle done is high.
    do_start(MODE_MAX, 1'b0, 5'd2);
    sb.push_back('{r: 32'd2, i: 4'd1});
    send(32'd1);
    send(32'd2);
    finish_check("b2b_first");
    do_start(MODE_MIN, 1'b0, 5'd3);
    check("b2b_done_clear", {31'b0, done}, 32'd0);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    sb.push_back('{r: 32'd6, i: 4'd1});
    send(32'd8);
    send(32'd6);
    send(32'd6);
    finish_check("b2b_second");

    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
